// File: rtl/cpu_pkg.sv
// Shared miniCPU definitions: instruction width and field map, special opcodes,
// and the fetch/decode sequencer state encoding.
package cpu_pkg;

  localparam int unsigned INSTR_WIDTH = 16;

  localparam int unsigned OP_MSB  = 15;
  localparam int unsigned OP_LSB  = 12;
  localparam int unsigned DST_MSB = 11;
  localparam int unsigned DST_LSB = 8;
  localparam int unsigned S1_MSB  = 7;
  localparam int unsigned S1_LSB  = 4;
  localparam int unsigned S2_MSB  = 3;
  localparam int unsigned S2_LSB  = 0;
  localparam int unsigned TGT_MSB = 7;
  localparam int unsigned TGT_LSB = 0;

  localparam logic [3:0] OP_HALT = 4'hF;
  localparam logic [3:0] OP_JUMP = 4'hE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_ISSUE,
    ST_HALT
  } fd_state_e;

endpackage

// File: rtl/fd_instr_split.sv
// Combinational split of an instruction word into opcode and register fields;
// shared with any later disassembly/trace logic.
module fd_instr_split
  import cpu_pkg::*;
#(
  parameter int unsigned INSTR_W = INSTR_WIDTH
) (
  input  logic [INSTR_W-1:0] instr_i,
  output logic [3:0]         opcode_o,
  output logic [3:0]         dstadd_o,
  output logic [3:0]         srcadd_1_o,
  output logic [3:0]         srcadd_2_o
);

  assign opcode_o   = instr_i[OP_MSB:OP_LSB];
  assign dstadd_o   = instr_i[DST_MSB:DST_LSB];
  assign srcadd_1_o = instr_i[S1_MSB:S1_LSB];
  assign srcadd_2_o = instr_i[S2_MSB:S2_LSB];

endmodule

// File: rtl/fetch_decode.sv
// miniCPU front end: fetches one instruction at a time, decodes it and hands it
// to execute. Optional FD_JUMP_EN makes opcode 4'hE an unconditional jump.
module fetch_decode
  import cpu_pkg::*;
#(
  parameter int unsigned      PC_W     = 8,
  parameter int unsigned      INSTR_W  = INSTR_WIDTH,
  parameter logic [PC_W-1:0]  RESET_PC = '0,
  parameter logic [3:0]       HALT_OP  = OP_HALT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [3:0]         opcode,
  output logic [3:0]         dstadd,
  output logic [3:0]         srcadd_1,
  output logic [3:0]         srcadd_2,
  output logic               issue_valid,
  input  logic               exec_ready,
  output logic [PC_W-1:0]    pc,
  output logic               halted
);

  fd_state_e          state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // Fields come straight from the instruction register, so they hold the last
  // fetched word until the next fetch completes.
  fd_instr_split #(
    .INSTR_W (INSTR_W)
  ) u_split (
    .instr_i    (instr_q),
    .opcode_o   (opcode),
    .dstadd_o   (dstadd),
    .srcadd_1_o (srcadd_1),
    .srcadd_2_o (srcadd_2)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_ready) begin
          instr_d = imem_rdata;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (opcode == HALT_OP) begin
          state_d = ST_HALT;
        end
`ifdef FD_JUMP_EN
        else if (opcode == OP_JUMP) begin
          pc_d    = PC_W'(instr_q[TGT_MSB:TGT_LSB]);
          state_d = ST_FETCH;
        end
`endif
        else begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (exec_ready) begin
          pc_d    = pc_q + PC_W'(1);
          state_d = ST_FETCH;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign imem_req    = (state_q == ST_FETCH);
  assign imem_addr   = pc_q;
  assign issue_valid = (state_q == ST_ISSUE);
  assign halted      = (state_q == ST_HALT);
  assign pc          = pc_q;

endmodule

// File: tb/tb_fetch_decode.sv
// Directed bench for fetch_decode: handshake timing, stalls, reset, wrap, halt
// and opcode 4'hE handling (jump or issue depending on FD_JUMP_EN).
module tb_fetch_decode;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ready;
  logic [15:0] imem_rdata;
  logic [3:0]  opcode, dstadd, srcadd_1, srcadd_2;
  logic        issue_valid;
  logic        exec_ready;
  logic [7:0]  pc;
  logic        halted;

  logic [15:0] mem [256];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  bit          found;

  always #5 clk = ~clk;

  assign imem_rdata = mem[imem_addr];

  fetch_decode #(
    .PC_W     (8),
    .INSTR_W  (16),
    .RESET_PC (8'h00),
    .HALT_OP  (4'hF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .opcode      (opcode),
    .dstadd      (dstadd),
    .srcadd_1    (srcadd_1),
    .srcadd_2    (srcadd_2),
    .issue_valid (issue_valid),
    .exec_ready  (exec_ready),
    .pc          (pc),
    .halted      (halted)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; imem_ready = 1'b0; exec_ready = 1'b0;
    for (int unsigned i = 0; i < 256; i++) mem[i] = 16'h3ABC;
    mem[0] = 16'h1234;
    mem[1] = 16'h2567;

    repeat (2) tick();
    check("rst_pc", pc, 8'h00);
    check("rst_req", imem_req, 1'b0);
    check("rst_valid", issue_valid, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_opcode", opcode, 4'h0);
    reset = 1'b0;
    tick();
    check("idle_req", imem_req, 1'b0);

    // 1: zero-wait instruction
    imem_ready = 1'b1; exec_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    check("t1_req", imem_req, 1'b1);
    check("t1_addr", imem_addr, 8'h00);
    check("t1_valid_fetch", issue_valid, 1'b0);
    tick();
    imem_ready = 1'b0;
    check("t1_valid_decode", issue_valid, 1'b0);
    check("t1_op_decode", opcode, 4'h1);
    tick();
    check("t1_valid", issue_valid, 1'b1);
    check("t1_fields", {opcode, dstadd, srcadd_1, srcadd_2}, 16'h1234);
    check("t1_pc_issue", pc, 8'h00);
    tick();
    check("t1_pc_next", pc, 8'h01);
    check("t1_valid_off", issue_valid, 1'b0);
    check("t1_addr_next", imem_addr, 8'h01);

    // 2: delayed imem_ready
    exec_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t2_req_hold", imem_req, 1'b1);
      check("t2_addr_hold", imem_addr, 8'h01);
      check("t2_no_issue", issue_valid, 1'b0);
    end
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    check("t2_op_decode", opcode, 4'h2);
    tick();
    check("t2_valid", issue_valid, 1'b1);
    check("t2_fields", {opcode, dstadd, srcadd_1, srcadd_2}, 16'h2567);

    // 3: exec_ready stall
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_valid_hold", issue_valid, 1'b1);
      check("t3_fields_hold", {opcode, dstadd, srcadd_1, srcadd_2}, 16'h2567);
      check("t3_pc_hold", pc, 8'h01);
    end
    exec_ready = 1'b1;
    tick();
    exec_ready = 1'b0;
    check("t3_pc_accept", pc, 8'h02);
    check("t3_valid_off", issue_valid, 1'b0);

    // reset while fetching at pc 2
    check("rf_in_fetch", imem_req, 1'b1);
    reset = 1'b1;
    tick();
    check("rf_pc", pc, 8'h00);
    check("rf_req", imem_req, 1'b0);
    reset = 1'b0;
    tick();
    check("rf_idle", imem_req, 1'b0);

    // reset while issuing, with exec_ready high: no increment
    start = 1'b1; imem_ready = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("ri_valid", issue_valid, 1'b1);
    exec_ready = 1'b1; reset = 1'b1;
    tick();
    check("ri_pc", pc, 8'h00);
    check("ri_valid_off", issue_valid, 1'b0);
    reset = 1'b0;
    tick();

    // 5: run to pc FF and wrap
    start = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (issue_valid && pc == 8'hFF) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("t5_reach_ff", found, 1'b1);
    check("t5_op", opcode, 4'h3);
    tick();
    check("t5_pc_wrap", pc, 8'h00);
    check("t5_addr_wrap", imem_addr, 8'h00);
    check("t5_req", imem_req, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();

    // 4: halt at pc 05
    mem[5] = 16'hF000;
    start = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (halted) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("t4_halted", found, 1'b1);
    check("t4_pc", pc, 8'h05);
    check("t4_req", imem_req, 1'b0);
    check("t4_valid", issue_valid, 1'b0);
    start = 1'b1; imem_ready = 1'b1; exec_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_stay", {halted, imem_req, issue_valid}, 3'b100);
      check("t4_pc_hold", pc, 8'h05);
    end
    start = 1'b0;
    reset = 1'b1;
    tick();
    check("t4_rst_halted", halted, 1'b0);
    check("t4_rst_pc", pc, 8'h00);
    reset = 1'b0;
    mem[5] = 16'h3ABC;
    tick();

    // 6: opcode E at pc 03
    mem[3] = 16'hE042;
    start = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (imem_req && imem_addr == 8'h03) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("t6_fetch3", found, 1'b1);
    tick();
    check("t6_op_decode", opcode, 4'hE);
    check("t6_valid_decode", issue_valid, 1'b0);
    tick();
`ifdef FD_JUMP_EN
    check("t6_jmp_valid", issue_valid, 1'b0);
    check("t6_jmp_req", imem_req, 1'b1);
    check("t6_jmp_addr", imem_addr, 8'h42);
`else
    check("t6_alu_valid", issue_valid, 1'b1);
    check("t6_alu_fields", {opcode, dstadd, srcadd_1, srcadd_2}, 16'hE042);
    check("t6_alu_pc", pc, 8'h03);
    tick();
    check("t6_alu_pc_inc", pc, 8'h04);
    check("t6_alu_addr", imem_addr, 8'h04);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
